// File: rtl/risc_toy_mem_stage.sv
// rtl/risc_toy_mem_stage.sv - RISC_TOY MEM stage: M/W registers, load-latency FSM, forwarding info
// Optional: define MEM_MISALIGN_CHK_EN to retire misaligned loads/stores without a memory access.
module risc_toy_mem_stage #(
    parameter int unsigned MEM_LAT = 1
) (
    input  logic        clk_i,
    input  logic        rstn_i,
    input  logic        x_valid_i,
    output logic        x_ready_o,
    input  logic [31:0] x_alu_res_i,
    input  logic [31:0] x_st_data_i,
    input  logic [1:0]  x_memop_i,
    input  logic        x_wen_i,
    input  logic [4:0]  x_wa_i,
    output logic        dreq_o,
    output logic        drw_o,
    output logic [29:0] daddr_o,
    output logic [31:0] dwdata_o,
    input  logic [31:0] drdata_i,
    output logic        w_valid_o,
    output logic        w_wen_o,
    output logic [4:0]  w_wa_o,
    output logic [31:0] w_wd_o,
    output logic        m_fwd_en_o,
    output logic [4:0]  m_fwd_wa_o,
    output logic [31:0] m_fwd_wd_o,
    output logic        load_haz_o,
    output logic        misalign_o
);

    typedef enum logic [1:0] {ST_IDLE, ST_REQ, ST_WAIT} state_e;
    localparam logic [1:0] CNT_INIT = 2'(MEM_LAT - 1);

    state_e      state_q;
    logic [1:0]  cnt_q;
    logic        m_valid_q, m_ld_q, m_st_q, m_mis_q, m_wen_q;
    logic [4:0]  m_wa_q;
    logic [31:0] m_alu_q, m_st_data_q;
    logic        w_valid_q, w_wen_q, w_mis_q;
    logic [4:0]  w_wa_q;
    logic [31:0] w_wd_q;
    logic        accept, m_ld_d, m_st_d, m_mis_d, m_wen_d;

    // Decode at accept time so M only remembers what each op actually does.
    always_comb begin
`ifdef MEM_MISALIGN_CHK_EN
        m_mis_d = ((x_memop_i == 2'b01) || (x_memop_i == 2'b10)) && (x_alu_res_i[1:0] != 2'b00);
`else
        m_mis_d = 1'b0;
`endif
        m_ld_d  = (x_memop_i == 2'b01) && !m_mis_d;
        m_st_d  = (x_memop_i == 2'b10) && !m_mis_d;
        m_wen_d = x_wen_i && (x_memop_i != 2'b10) && !m_mis_d;
    end

    assign x_ready_o = (state_q == ST_IDLE) || ((state_q == ST_WAIT) && (cnt_q == 2'd0));
    assign accept    = x_valid_i && x_ready_o;

    always_ff @(posedge clk_i or negedge rstn_i) begin
        if (!rstn_i) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 2'd0;
            m_valid_q   <= 1'b0;
            m_ld_q      <= 1'b0;
            m_st_q      <= 1'b0;
            m_mis_q     <= 1'b0;
            m_wen_q     <= 1'b0;
            m_wa_q      <= 5'd0;
            m_alu_q     <= 32'd0;
            m_st_data_q <= 32'd0;
            w_valid_q   <= 1'b0;
            w_wen_q     <= 1'b0;
            w_mis_q     <= 1'b0;
            w_wa_q      <= 5'd0;
            w_wd_q      <= 32'd0;
        end else begin
            w_valid_q <= 1'b0;
            w_wen_q   <= 1'b0;
            w_mis_q   <= 1'b0;
            if ((state_q == ST_WAIT) && (cnt_q == 2'd0)) begin
                w_valid_q <= 1'b1;
                w_wen_q   <= m_wen_q;
                w_wa_q    <= m_wa_q;
                w_wd_q    <= drdata_i;
            end else if ((state_q == ST_IDLE) && m_valid_q) begin
                w_valid_q <= 1'b1;
                w_wen_q   <= m_wen_q;
                w_wa_q    <= m_wa_q;
                w_wd_q    <= m_alu_q;
                w_mis_q   <= m_mis_q;
            end

            if (accept) begin
                m_valid_q   <= 1'b1;
                m_ld_q      <= m_ld_d;
                m_st_q      <= m_st_d;
                m_mis_q     <= m_mis_d;
                m_wen_q     <= m_wen_d;
                m_wa_q      <= x_wa_i;
                m_alu_q     <= x_alu_res_i;
                m_st_data_q <= x_st_data_i;
                state_q     <= m_ld_d ? ST_REQ : ST_IDLE;
            end else if (x_ready_o) begin
                m_valid_q <= 1'b0;
                state_q   <= ST_IDLE;
            end else if (state_q == ST_REQ) begin
                state_q <= ST_WAIT;
                cnt_q   <= CNT_INIT;
            end else begin
                cnt_q <= cnt_q - 2'd1;
            end
        end
    end

    assign dreq_o     = m_valid_q && (m_st_q || (state_q == ST_REQ));
    assign drw_o      = m_valid_q && m_st_q;
    assign daddr_o    = m_alu_q[31:2];
    assign dwdata_o   = m_st_data_q;
    assign w_valid_o  = w_valid_q;
    assign w_wen_o    = w_wen_q;
    assign w_wa_o     = w_wa_q;
    assign w_wd_o     = w_wd_q;
    assign m_fwd_en_o = m_valid_q && !m_ld_q && m_wen_q;
    assign m_fwd_wa_o = m_wa_q;
    assign m_fwd_wd_o = m_alu_q;
    assign load_haz_o = m_valid_q && m_ld_q;
    assign misalign_o = w_mis_q;

endmodule

// File: tb/tb_risc_toy_mem_stage.sv
// tb/tb_risc_toy_mem_stage.sv - bench for risc_toy_mem_stage, instances with MEM_LAT=1 and MEM_LAT=3
module tb_risc_toy_mem_stage;

    logic        clk = 1'b0;
    logic        rstn;
    logic        x_valid[2], x_ready[2], x_wen[2];
    logic [31:0] x_alu[2], x_st[2];
    logic [1:0]  x_memop[2];
    logic [4:0]  x_wa[2];
    logic        dreq[2], drw[2];
    logic [29:0] daddr[2];
    logic [31:0] dwdata[2], drdata[2];
    logic        w_valid[2], w_wen[2];
    logic [4:0]  w_wa[2];
    logic [31:0] w_wd[2];
    logic        fwd_en[2], load_haz[2], misalign[2];
    logic [4:0]  fwd_wa[2];
    logic [31:0] fwd_wd[2];

    int checks = 0;
    int errors = 0;
    int left[2] = '{-1, -1};
    logic [29:0] raddr[2];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_dut
        risc_toy_mem_stage #(.MEM_LAT((g == 0) ? 1 : 3)) u_dut (
            .clk_i(clk), .rstn_i(rstn),
            .x_valid_i(x_valid[g]), .x_ready_o(x_ready[g]),
            .x_alu_res_i(x_alu[g]), .x_st_data_i(x_st[g]), .x_memop_i(x_memop[g]),
            .x_wen_i(x_wen[g]), .x_wa_i(x_wa[g]),
            .dreq_o(dreq[g]), .drw_o(drw[g]), .daddr_o(daddr[g]), .dwdata_o(dwdata[g]),
            .drdata_i(drdata[g]),
            .w_valid_o(w_valid[g]), .w_wen_o(w_wen[g]), .w_wa_o(w_wa[g]), .w_wd_o(w_wd[g]),
            .m_fwd_en_o(fwd_en[g]), .m_fwd_wa_o(fwd_wa[g]), .m_fwd_wd_o(fwd_wd[g]),
            .load_haz_o(load_haz[g]), .misalign_o(misalign[g])
        );
    end

    function automatic int lat_of(input int g);
        return (g == 0) ? 1 : 3;
    endfunction

    function automatic logic [31:0] mem_word(input logic [29:0] a);
        if (a == 30'h81) return 32'hCAFEF00D;
        return ({2'b00, a} * 32'h9E3779B1) + 32'h01234567;
    endfunction

    // Memory: a read issued in cycle c returns its word only during cycle c+MEM_LAT; garbage otherwise.
    always @(negedge clk) begin
        for (int g = 0; g < 2; g++)
            if (dreq[g] && !drw[g]) begin
                left[g]  = lat_of(g);
                raddr[g] = daddr[g];
            end
    end
    always @(posedge clk) begin
        #1;
        for (int g = 0; g < 2; g++) begin
            if (left[g] > 0) left[g]--;
            if (left[g] == 0) begin
                drdata[g] = mem_word(raddr[g]);
                left[g]   = -1;
            end else begin
                drdata[g] = $urandom;
            end
        end
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    typedef struct {
        int          g;
        logic [1:0]  op;
        logic [31:0] alu, st;
        bit          wen;
        logic [4:0]  wa;
        bit          e_dreq, e_drw;
        logic [29:0] e_daddr;
        bit          e_wen, e_mis;
        logic [31:0] e_wd;
        int          e_lat;
        bit          e_fwd;
    } vec_t;

    typedef struct {
        bit          v, wen, mis;
        logic [4:0]  wa;
        logic [31:0] wd;
    } ret_t;

    typedef struct {
        bit          v, rw;
        logic [29:0] a;
        logic [31:0] d;
    } req_t;

    task automatic drive(input int g, input logic [1:0] op, input logic [31:0] alu,
                         input logic [31:0] st, input bit wen, input logic [4:0] wa);
        x_memop[g] = op; x_alu[g] = alu; x_st[g] = st; x_wen[g] = wen; x_wa[g] = wa;
        x_valid[g] = 1'b1;
    endtask

    task automatic apply_vec(input vec_t v, input int idx);
        int  k = 0;
        int  g = v.g;
        @(negedge clk);
        chk($sformatf("v%0d ready", idx), x_ready[g], 1);
        drive(g, v.op, v.alu, v.st, v.wen, v.wa);
        @(negedge clk);
        x_valid[g] = 1'b0;
        chk($sformatf("v%0d dreq", idx), dreq[g], v.e_dreq);
        if (v.e_dreq) begin
            chk($sformatf("v%0d drw", idx), drw[g], v.e_drw);
            chk($sformatf("v%0d daddr", idx), daddr[g], v.e_daddr);
            if (v.e_drw) chk($sformatf("v%0d dwdata", idx), dwdata[g], v.st);
        end
        chk($sformatf("v%0d load_haz", idx), load_haz[g], v.e_lat > 1);
        chk($sformatf("v%0d ready_t", idx), x_ready[g], (v.e_lat == 1) || (lat_of(g) == 1 && v.e_lat > 1 && 1'b0));
        chk($sformatf("v%0d fwd_en", idx), fwd_en[g], v.e_fwd);
        if (v.e_fwd) chk($sformatf("v%0d fwd_wd", idx), fwd_wd[g], v.alu);
        for (int i = 1; i <= 8; i++) begin
            @(negedge clk);
            if (w_valid[g]) begin k = i; break; end
        end
        chk($sformatf("v%0d latency", idx), k, v.e_lat);
        if (k != 0) begin
            chk($sformatf("v%0d w_wen", idx), w_wen[g], v.e_wen);
            chk($sformatf("v%0d w_wa", idx), w_wa[g], v.wa);
            chk($sformatf("v%0d misalign", idx), misalign[g], v.e_mis);
            if (v.e_wen) chk($sformatf("v%0d w_wd", idx), w_wd[g], v.e_wd);
            @(negedge clk);
            chk($sformatf("v%0d pulse", idx), w_valid[g], 0);
        end
    endtask

    task automatic run_random(input int g, input int ncyc);
        ret_t ret[1024];
        req_t req[1024];
        ret_t fwd[1024];
        bit   haz[1024];
        int   next_ok = 0;
        int   t, lat;
        bit   hold = 0, ready, is_ld, is_st, mis;
        for (int i = 0; i < 1024; i++) begin
            ret[i] = '{default: '0}; req[i] = '{default: '0};
            fwd[i] = '{default: '0}; haz[i] = 1'b0;
        end
        for (int c = 0; c < ncyc; c++) begin
            @(negedge clk);
            ready = (c + 1 >= next_ok);
            chk("rnd x_ready", x_ready[g], ready);
            chk("rnd w_valid", w_valid[g], ret[c].v);
            if (ret[c].v) begin
                chk("rnd w_wen", w_wen[g], ret[c].wen);
                chk("rnd w_wa", w_wa[g], ret[c].wa);
                if (ret[c].wen) chk("rnd w_wd", w_wd[g], ret[c].wd);
            end
            chk("rnd misalign", misalign[g], ret[c].v && ret[c].mis);
            chk("rnd dreq", dreq[g], req[c].v);
            if (req[c].v) begin
                chk("rnd drw", drw[g], req[c].rw);
                chk("rnd daddr", daddr[g], req[c].a);
                if (req[c].rw) chk("rnd dwdata", dwdata[g], req[c].d);
            end
            chk("rnd load_haz", load_haz[g], haz[c]);
            chk("rnd fwd_en", fwd_en[g], fwd[c].v);
            if (fwd[c].v) begin
                chk("rnd fwd_wa", fwd_wa[g], fwd[c].wa);
                chk("rnd fwd_wd", fwd_wd[g], fwd[c].wd);
            end
            if (!hold) begin
                x_valid[g] = ($urandom_range(0, 9) < 7);
                x_memop[g] = 2'($urandom_range(0, 3));
                x_alu[g]   = $urandom;
                if ($urandom_range(0, 3) != 0) x_alu[g][1:0] = 2'b00;
                x_st[g]    = $urandom;
                x_wen[g]   = 1'($urandom_range(0, 1));
                x_wa[g]    = 5'($urandom_range(0, 31));
            end
            hold = x_valid[g] && !ready;
            if (x_valid[g] && ready) begin
                t     = c + 1;
                is_ld = (x_memop[g] == 2'b01);
                is_st = (x_memop[g] == 2'b10);
                mis   = 1'b0;
`ifdef MEM_MISALIGN_CHK_EN
                mis   = (is_ld || is_st) && (x_alu[g][1:0] != 2'b00);
`endif
                lat = (is_ld && !mis) ? lat_of(g) : 0;
                ret[t + 1 + lat] = '{1'b1, x_wen[g] && !is_st && !mis, mis, x_wa[g],
                                     (is_ld && !mis) ? mem_word(x_alu[g][31:2]) : x_alu[g]};
                if ((is_ld || is_st) && !mis) req[t] = '{1'b1, is_st, x_alu[g][31:2], x_st[g]};
                if (is_ld && !mis) begin
                    for (int k = t; k <= t + lat; k++) haz[k] = 1'b1;
                end else if (x_wen[g] && !is_st && !mis) begin
                    fwd[t] = '{1'b1, 1'b1, 1'b0, x_wa[g], x_alu[g]};
                end
                next_ok = t + 1 + lat;
            end
        end
        x_valid[g] = 1'b0;
    endtask

    task automatic pulse_reset();
        @(negedge clk);
        rstn = 1'b0;
        @(negedge clk);
        rstn = 1'b1;
    endtask

    vec_t vecs[8];
    int   lowcnt;
    bit   acc, seen;

    initial begin
        #400000;
        $display("FAIL watchdog: run did not complete");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{0, 2'b00, 32'h00001234, 32'h0, 1, 5'd3, 0, 0, 30'h0, 1, 0, 32'h00001234, 1, 1};
        vecs[1] = '{0, 2'b10, 32'h00000100, 32'hDEADBEEF, 0, 5'd0, 1, 1, 30'h40, 0, 0, 32'h0, 1, 0};
        vecs[2] = '{0, 2'b01, 32'h00000204, 32'h0, 1, 5'd7, 1, 0, 30'h81, 1, 0, 32'hCAFEF00D, 2, 0};
        vecs[3] = '{1, 2'b01, 32'h00000208, 32'h0, 1, 5'd12, 1, 0, 30'h82, 1, 0, mem_word(30'h82), 4, 0};
        vecs[4] = '{0, 2'b11, 32'h000055AA, 32'h0, 1, 5'd31, 0, 0, 30'h0, 1, 0, 32'h000055AA, 1, 1};
`ifdef MEM_MISALIGN_CHK_EN
        vecs[5] = '{0, 2'b01, 32'h00000202, 32'h0, 1, 5'd9, 0, 0, 30'h0, 0, 1, 32'h0, 1, 0};
        vecs[6] = '{1, 2'b10, 32'hFFFFFFFD, 32'h01234567, 0, 5'd1, 0, 0, 30'h0, 0, 1, 32'h0, 1, 0};
`else
        vecs[5] = '{0, 2'b01, 32'h00000202, 32'h0, 1, 5'd9, 1, 0, 30'h80, 1, 0, mem_word(30'h80), 2, 0};
        vecs[6] = '{1, 2'b10, 32'hFFFFFFFD, 32'h01234567, 0, 5'd1, 1, 1, 30'h3FFFFFFF, 0, 0, 32'h0, 1, 0};
`endif
        vecs[7] = '{1, 2'b00, 32'h80000001, 32'h0, 0, 5'd4, 0, 0, 30'h0, 0, 0, 32'h0, 1, 0};

        for (int g = 0; g < 2; g++) begin
            x_valid[g] = 0; x_memop[g] = 0; x_alu[g] = 0; x_st[g] = 0; x_wen[g] = 0; x_wa[g] = 0;
        end
        rstn = 1'b0;
        repeat (3) @(negedge clk);
        for (int g = 0; g < 2; g++) begin
            chk("reset x_ready", x_ready[g], 1);
            chk("reset flags", {dreq[g], drw[g], w_valid[g], w_wen[g], fwd_en[g], load_haz[g], misalign[g]}, 0);
            chk("reset daddr|dwdata", {2'b00, daddr[g]} | dwdata[g], 0);
            chk("reset w_wd|w_wa|fwd", w_wd[g] | fwd_wd[g] | {27'd0, w_wa[g] | fwd_wa[g]}, 0);
        end
        rstn = 1'b1;

        for (int i = 0; i < 8; i++) apply_vec(vecs[i], i);

        // Reset while inst1 waits on a load and inst0 is driving a store request.
        @(negedge clk);
        drive(1, 2'b01, 32'h100, 32'h0, 1, 5'd5);
        @(negedge clk);
        x_valid[1] = 1'b0;
        drive(0, 2'b10, 32'h104, 32'h11223344, 0, 5'd0);
        @(negedge clk);
        x_valid[0] = 1'b0;
        chk("rst pre dreq0", dreq[0], 1);
        chk("rst pre haz1", load_haz[1], 1);
        rstn = 1'b0;
        #1;
        chk("rst dreq0", dreq[0], 0);
        chk("rst dreq1", dreq[1], 0);
        chk("rst w_valid1", w_valid[1], 0);
        chk("rst x_ready1", x_ready[1], 1);
        @(negedge clk);
        rstn = 1'b1;
        seen = 0;
        repeat (8) begin
            @(negedge clk);
            if (w_valid[1]) seen = 1;
        end
        chk("rst no late W", seen, 0);

        // MEM_LAT=3 load followed by an ADD held on X.
        @(negedge clk);
        drive(1, 2'b01, 32'h300, 32'h0, 1, 5'd7);
        @(negedge clk);
        drive(1, 2'b00, 32'h1234, 32'h0, 1, 5'd3);
        lowcnt = 0; acc = 0;
        for (int i = 0; i < 12; i++) begin
            if (x_ready[1]) begin acc = 1; break; end
            lowcnt++;
            @(negedge clk);
        end
        chk("hold accepted", acc, 1);
        chk("hold ready low cycles", lowcnt, 3);
        @(negedge clk);
        x_valid[1] = 1'b0;
        chk("hold load W", w_valid[1], 1);
        chk("hold load wa", w_wa[1], 7);
        chk("hold load wd", w_wd[1], mem_word(30'hC0));
        @(negedge clk);
        chk("hold add W", w_valid[1], 1);
        chk("hold add wa", w_wa[1], 3);
        chk("hold add wd", w_wd[1], 32'h1234);
        @(negedge clk);
        chk("hold no dup", w_valid[1], 0);

        for (int g = 0; g < 2; g++) begin
            pulse_reset();
            run_random(g, 500);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
